// File: rtl/imem_access_arbiter_if.sv
// imem_access_arbiter_if: fetch, loader and Memory32 signals of the instruction-memory arbiter
interface imem_access_arbiter_if #(
   parameter int ADDRESS_WIDTH     = 9,
   parameter int INSTRUCTION_WIDTH = 32
);
   logic                         fetch_req;
   logic [ADDRESS_WIDTH-1:0]     fetch_addr;
   logic                         fetch_gnt;
   logic                         fetch_valid;
   logic [INSTRUCTION_WIDTH-1:0] fetch_instr;
   logic                         load_req;
   logic [ADDRESS_WIDTH-1:0]     load_addr;
   logic [INSTRUCTION_WIDTH-1:0] load_data;
   logic                         load_lock;
   logic                         load_gnt;
   logic                         locked;
   logic [31:0]                  mem_read_addr;
   logic [31:0]                  mem_write_addr;
   logic [INSTRUCTION_WIDTH-1:0] mem_data_in;
   logic                         mem_we;
   logic [INSTRUCTION_WIDTH-1:0] mem_data_out;
   modport master (
      output fetch_req, fetch_addr, load_req, load_addr, load_data, load_lock, mem_data_out,
      input  fetch_gnt, fetch_valid, fetch_instr, load_gnt, locked,
             mem_read_addr, mem_write_addr, mem_data_in, mem_we
   );
   modport slave (
      input  fetch_req, fetch_addr, load_req, load_addr, load_data, load_lock, mem_data_out,
      output fetch_gnt, fetch_valid, fetch_instr, load_gnt, locked,
             mem_read_addr, mem_write_addr, mem_data_in, mem_we
   );
endinterface

// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter: shares one Memory32 instruction store between the fetch (read) and loader (write) ports
module imem_access_arbiter #(
   parameter int ADDRESS_WIDTH     = 9,
   parameter int INSTRUCTION_WIDTH = 32,
   parameter int MAX_LOAD_BURST    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   imem_access_arbiter_if.slave  bus
);
   localparam logic [1:0] SHARED    = 2'd0;
   localparam logic [1:0] LOCK_WAIT = 2'd1;
   localparam logic [1:0] LOCKED    = 2'd2;
   localparam int BW = $clog2(MAX_LOAD_BURST + 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_LOAD_BURST);

   logic [1:0]    state_q, state_d;
   logic          last_load_q, last_load_d;
   logic [BW-1:0] burst_q, burst_d;
   logic          fetch_prev_q;
   logic          fetch_valid_q;
   logic          fetch_win;
   logic          fetch_gnt;
   logic          load_gnt;
   logic          valid;

   // Tie-break: a saturated burst forces fetch, a freshly raised fetch yields to the loader, otherwise round-robin
   assign fetch_win = (burst_q == BURST_MAX) || (fetch_prev_q && last_load_q);

   // Grants: arbitrated in SHARED, loader-only otherwise, nothing while in reset
   always_comb begin
      fetch_gnt = 1'b0;
      load_gnt  = 1'b0;
      if (!reset) begin
         fetch_gnt = (state_q == SHARED) && bus.fetch_req && (!bus.load_req || fetch_win);
         load_gnt  = bus.load_req && !fetch_gnt;
      end
   end

   // Next state; LOCK_WAIT never grants fetch, so nothing is in flight once it has lasted one cycle
   always_comb begin
      state_d     = (state_q == SHARED) ? (bus.load_lock ? LOCK_WAIT : SHARED) :
                    (bus.load_lock && (state_q == LOCK_WAIT || state_q == LOCKED)) ? LOCKED : SHARED;
      last_load_d = fetch_gnt ? 1'b0 : (load_gnt ? 1'b1 : last_load_q);
      burst_d     = (fetch_gnt || state_q == LOCKED || state_d == LOCKED) ? '0 :
                    (load_gnt && bus.fetch_req && burst_q != BURST_MAX) ? burst_q + 1'b1 : burst_q;
   end

   // State, arbitration history and read-response registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= SHARED;
         last_load_q   <= 1'b1;
         burst_q       <= '0;
         fetch_prev_q  <= 1'b0;
         fetch_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_load_q   <= last_load_d;
         burst_q       <= burst_d;
         fetch_prev_q  <= bus.fetch_req;
         fetch_valid_q <= fetch_gnt;
      end
   end

   assign valid              = fetch_valid_q && !reset;
   assign bus.fetch_gnt      = fetch_gnt;
   assign bus.load_gnt       = load_gnt;
   assign bus.mem_we         = load_gnt;
   assign bus.fetch_valid    = valid;
   assign bus.fetch_instr    = valid ? bus.mem_data_out : {INSTRUCTION_WIDTH{1'b0}};
   assign bus.locked         = (state_q == LOCKED);
   assign bus.mem_read_addr  = {{(32-ADDRESS_WIDTH){1'b0}}, bus.fetch_addr};
   assign bus.mem_write_addr = {{(32-ADDRESS_WIDTH){1'b0}}, bus.load_addr};
   assign bus.mem_data_in    = bus.load_data;
endmodule
